ps2_key_decoder: RTL and testbench
==================================

# ps2_key_decoder

Receives PS/2 keyboard frames and turns the four players' direction keys, plus the game-reset key, into the 5-bit `KEY_PRESSED` code consumed by the game core. It sits directly upstream of `game`. It synchronises the raw PS/2 clock and data pins, deserialises 11-bit frames, tracks the E0 (extended) and F0 (break) prefixes, and holds the code of the currently pressed mapped key.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 50000: CLOCK_50 cycles with no PS/2 falling edge before a partial frame is aborted (1 ms).

Ports:
- `CLOCK_50`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `PS2_CLK`  in  1  raw keyboard clock; asynchronous to `CLOCK_50`.
- `PS2_DAT`  in  1  raw keyboard data; asynchronous to `CLOCK_50`.
- `KEY_PRESSED`  out  5  code of the held key (codes listed under Operation); 5'd31 means no mapped key is held.
- `key_strobe`  out  1  one-cycle pulse when `KEY_PRESSED` takes a new value from a make code.
- `frame_error`  out  1  one-cycle pulse when a frame is discarded for a bad stop bit, bad parity or timeout.

## Operation

**Synchronisation**
- `PS2_CLK` and `PS2_DAT` each pass through a 2-flop synchroniser.
- A falling edge is detected when the synchronised clock is 0 and its previous value is 1.

**Receiver FSM** (advances only on detected falling edges)
- IDLE: if data = 0 (start bit), go to DATA with the bit count cleared. If data = 1, stay in IDLE; this is not an error.
- DATA: shift data in LSB first. After 8 bits, go to PARITY.
- PARITY: capture the parity bit and go to STOP.
- STOP: if stop = 1 and the frame passes the parity check, assert `byte_valid` for one cycle with the byte. Otherwise pulse `frame_error`. Either way, return to IDLE.
- Timeout: outside IDLE, an idle counter counts cycles with no falling edge. When it reaches `TIMEOUT_CYCLES`, the FSM returns to IDLE, pulses `frame_error` and clears the prefix flags.
- Any discarded frame also clears the prefix flags `ext` and `brk`.

**Byte layer**
- Byte E0 sets `ext`.
- Byte F0 sets `brk`.
- Any other byte is looked up with the current `ext`, then both flags clear.

**Code map** (code = 4·player + dir; dir 00 up, 01 down, 10 left, 11 right)
- Player 1, extended arrows: E0 75 → 0, E0 72 → 1, E0 6B → 2, E0 74 → 3.
- Player 2, WASD: 1D → 4, 1B → 5, 1C → 6, 23 → 7.
- Player 3, IKJL: 43 → 8, 42 → 9, 3B → 10, 4B → 11.
- Player 4, numpad (not extended): 75 → 12, 73 → 13, 6B → 14, 74 → 15.
- Space 29 → 16, meaning game reset.
- Bytes 75, 6B, 74 map differently depending on `ext`; they must not alias.

**Make handling**
- A mapped code that differs from `KEY_PRESSED` loads `KEY_PRESSED` and pulses `key_strobe`.
- A mapped code equal to `KEY_PRESSED` (typematic repeat) does nothing.
- An unmapped byte does nothing.

**Break handling**
- A mapped code equal to `KEY_PRESSED` sets `KEY_PRESSED` to 31 with no strobe.
- Any other break changes nothing.

**Reset**
- Asynchronous reset sets `KEY_PRESSED` = 31, `key_strobe` = 0, `frame_error` = 0.
- Reset also returns the FSM to IDLE and clears `ext`, `brk` and all counters.
- A frame in flight when reset is asserted is lost. Its remaining bits are rejected by the IDLE start-bit rule, by the stop/parity checks, or by the timeout.

## Timing

- Latency from the raw `PS2_CLK` falling edge that carries the stop bit to the `KEY_PRESSED`/`key_strobe` update is exactly 4 `CLOCK_50` rising edges:
  - edges 1–2: synchroniser;
  - edge 3: the FSM samples the stop bit and registers `byte_valid`;
  - edge 4: the byte layer updates its outputs.
- `key_strobe` is high for exactly one cycle, the same cycle `KEY_PRESSED` first shows the new code.
- `frame_error` is asserted at edge 3 for stop/parity errors, and on the cycle the idle counter hits `TIMEOUT_CYCLES` for timeouts.
- All outputs are registered; there are no combinational paths from the pins.

## Configuration

- `PS2_PARITY_CHECK_EN` defined: a frame must have odd parity over its 8 data bits plus the parity bit. A parity failure discards the frame and pulses `frame_error`.
- `PS2_PARITY_CHECK_EN` undefined: the parity bit is captured but ignored. Only the stop bit and the timeout can discard a frame.

## Test plan

1. Arrow up:
   - E0, 75 → `KEY_PRESSED` = 0 with a one-cycle strobe, 4 cycles after the last stop-bit edge.
   - Then E0, F0, 75 → 31, no strobe.
2. Typematic repeat: 1D → 4 with strobe; 1D again → no strobe, value stays 4.
   - F0, 1B (a break of a different key) → value stays 4.
3. Prefix aliasing: 74 → 15; E0, 74 → 3; E0, F0, 74 → 31.
4. Parity error: frame 29 with even parity.
   - Macro defined → `frame_error` pulse, `KEY_PRESSED` unchanged at 31.
   - Macro undefined → 16 with strobe.
5. Timeout: 5 bits, then `PS2_CLK` held high for 50000 cycles → `frame_error` pulse, FSM in IDLE; a following good frame 1C → 6.
6. Reset mid-frame: hold 43 (`KEY_PRESSED` = 8), start a new frame, assert `reset` → `KEY_PRESSED` = 31 immediately (asynchronously). After release, no spurious strobe occurs, and a following good 42 → 9.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: maps the four players' direction keys and the space bar to a 5-bit held-key code.
// Optional macro PS2_PARITY_CHECK_EN enables odd-parity checking of each received frame.
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [4:0] KEY_PRESSED,
  output logic       key_strobe,
  output logic       frame_error
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0] NO_KEY = 5'd31;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rxState_e;

  logic [1:0]       clkSync_q, datSync_q;
  logic             clkPrev_q;
  logic             ps2Fall, ps2Data;

  rxState_e         state_q, state_d;
  logic [2:0]       bitCnt_q, bitCnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [CNT_W-1:0] idleCnt_q, idleCnt_d;
  logic             byteValid_q, byteValid_d;
  logic             frameErr_q, frameErr_d;
  logic             parityOk;

  logic [4:0]       key_q, key_d;
  logic             strobe_q, strobe_d;
  logic             ext_q, ext_d;
  logic             brk_q, brk_d;
  logic [4:0]       mappedCode;

  // Idle lines are high, so the synchronisers reset to 1 to avoid a false edge after reset.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      clkSync_q <= 2'b11;
      datSync_q <= 2'b11;
      clkPrev_q <= 1'b1;
    end else begin
      clkSync_q <= {clkSync_q[0], PS2_CLK};
      datSync_q <= {datSync_q[0], PS2_DAT};
      clkPrev_q <= clkSync_q[1];
    end
  end

  assign ps2Fall = ~clkSync_q[1] & clkPrev_q;
  assign ps2Data = datSync_q[1];

`ifdef PS2_PARITY_CHECK_EN
  logic parity_q, parity_d;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) parity_q <= 1'b0;
    else       parity_q <= parity_d;
  end

  always_comb begin
    parity_d = parity_q;
    if (ps2Fall && state_q == PARITY) parity_d = ps2Data;
  end

  assign parityOk = ^{shift_q, parity_q};
`else
  assign parityOk = 1'b1;
`endif

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      idleCnt_q   <= '0;
      byteValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      shift_q     <= shift_d;
      idleCnt_q   <= idleCnt_d;
      byteValid_q <= byteValid_d;
      frameErr_q  <= frameErr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    idleCnt_d   = idleCnt_q;
    byteValid_d = 1'b0;
    frameErr_d  = 1'b0;
    if (ps2Fall) begin
      idleCnt_d = '0;
      unique case (state_q)
        IDLE: begin
          if (!ps2Data) begin
            state_d  = DATA;
            bitCnt_d = '0;
          end
        end
        DATA: begin
          shift_d  = {ps2Data, shift_q[7:1]};
          bitCnt_d = bitCnt_q + 3'd1;
          if (bitCnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: state_d = STOP;
        STOP: begin
          if (ps2Data && parityOk) byteValid_d = 1'b1;
          else                     frameErr_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      // A keyboard that stops clocking mid-frame must not wedge the receiver.
      if (idleCnt_q == TIMEOUT_LAST) begin
        state_d    = IDLE;
        idleCnt_d  = '0;
        frameErr_d = 1'b1;
      end else begin
        idleCnt_d = idleCnt_q + 1'b1;
      end
    end
  end

  // 75, 6B and 74 are both arrow keys (extended) and numpad keys (plain).
  function automatic logic [4:0] mapCode(input logic [7:0] b, input logic ext);
    logic [4:0] code;
    code = NO_KEY;
    if (ext) begin
      case (b)
        8'h75:   code = 5'd0;
        8'h72:   code = 5'd1;
        8'h6B:   code = 5'd2;
        8'h74:   code = 5'd3;
        default: code = NO_KEY;
      endcase
    end else begin
      case (b)
        8'h1D:   code = 5'd4;
        8'h1B:   code = 5'd5;
        8'h1C:   code = 5'd6;
        8'h23:   code = 5'd7;
        8'h43:   code = 5'd8;
        8'h42:   code = 5'd9;
        8'h3B:   code = 5'd10;
        8'h4B:   code = 5'd11;
        8'h75:   code = 5'd12;
        8'h73:   code = 5'd13;
        8'h6B:   code = 5'd14;
        8'h74:   code = 5'd15;
        8'h29:   code = 5'd16;
        default: code = NO_KEY;
      endcase
    end
    return code;
  endfunction

  assign mappedCode = mapCode(shift_q, ext_q);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      key_q    <= NO_KEY;
      strobe_q <= 1'b0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
    end else begin
      key_q    <= key_d;
      strobe_q <= strobe_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
    end
  end

  always_comb begin
    key_d    = key_q;
    strobe_d = 1'b0;
    ext_d    = ext_q;
    brk_d    = brk_q;
    if (frameErr_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byteValid_q) begin
      case (shift_q)
        8'hE0: ext_d = 1'b1;
        8'hF0: brk_d = 1'b1;
        default: begin
          ext_d = 1'b0;
          brk_d = 1'b0;
          if (mappedCode != NO_KEY) begin
            if (brk_q) begin
              if (mappedCode == key_q) key_d = NO_KEY;
            end else if (mappedCode != key_q) begin
              key_d    = mappedCode;
              strobe_d = 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign KEY_PRESSED = key_q;
  assign key_strobe  = strobe_q;
  assign frame_error = frameErr_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: the stimulus pushes expected output events,
// a negedge monitor pops and compares them, including stop-edge-to-output latency.
module tb_ps2_key_decoder;

   localparam int K_STROBE = 0;
   localparam int K_ERR    = 1;
   localparam int K_CHANGE = 2;

   typedef struct {
      int kind;
      int value;
      int lat;
   } expEvent_t;

   logic       CLOCK_50 = 1'b0;
   logic       reset;
   logic       PS2_CLK;
   logic       PS2_DAT;
   logic [4:0] KEY_PRESSED;
   logic       key_strobe;
   logic       frame_error;

   expEvent_t  expQ[$];
   int         checks = 0;
   int         errors = 0;
   int         cycleCnt = 0;
   int         lastFall = 0;
   bit         monitorOn = 1'b0;
   logic [4:0] prevKey = 5'd31;

   ps2_key_decoder dut (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .PS2_CLK     (PS2_CLK),
      .PS2_DAT     (PS2_DAT),
      .KEY_PRESSED (KEY_PRESSED),
      .key_strobe  (key_strobe),
      .frame_error (frame_error)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   // Count rising edges so the monitor can measure latency from the last PS/2 falling edge.
   always @(posedge CLOCK_50) cycleCnt++;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // The monitor treats a strobe, an error pulse or any silent change of the held code as one event.
   always @(negedge CLOCK_50) begin
      int        kind;
      expEvent_t e;
      if (monitorOn && (key_strobe || frame_error || KEY_PRESSED != prevKey)) begin
         kind = key_strobe ? K_STROBE : (frame_error ? K_ERR : K_CHANGE);
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedEvent: got kind %0d key %0d, expected no event", kind, KEY_PRESSED);
         end else begin
            e = expQ.pop_front();
            checkOutput("eventKind", kind, e.kind);
            if (e.kind != K_ERR) checkOutput("keyValue", int'(KEY_PRESSED), e.value);
            if (e.lat >= 0) checkOutput("latency", cycleCnt - lastFall, e.lat);
         end
      end
      prevKey = KEY_PRESSED;
   end

   task automatic expectEvent(input int kind, input int value, input int lat);
      expEvent_t e;
      e.kind  = kind;
      e.value = value;
      e.lat   = lat;
      expQ.push_back(e);
   endtask

   // One PS/2 bit: data settles, clock falls, clock rises; all changes on CLOCK_50 negedges.
   task automatic pulseBit(input logic d);
      @(negedge CLOCK_50);
      PS2_DAT = d;
      repeat (5) @(negedge CLOCK_50);
      PS2_CLK  = 1'b0;
      lastFall = cycleCnt;
      repeat (10) @(negedge CLOCK_50);
      PS2_CLK = 1'b1;
      repeat (5) @(negedge CLOCK_50);
   endtask

   // Sends the first nBits of an 11-bit frame, optionally corrupting parity or stop.
   task automatic applyStimulus(input logic [7:0] b, input bit badParity, input bit badStop, input int nBits);
      logic [10:0] frame;
      logic        par;
      par = ~^b;
      if (badParity) par = ~par;
      frame = {~badStop, par, b, 1'b0};
      for (int i = 0; i < nBits; i++) pulseBit(frame[i]);
      PS2_DAT = 1'b1;
      repeat (10) @(negedge CLOCK_50);
   endtask

   task automatic sendByte(input logic [7:0] b);
      applyStimulus(b, 1'b0, 1'b0, 11);
   endtask

   task automatic waitDrain(input int budget);
      int n;
      n = 0;
      while (expQ.size() != 0 && n < budget) begin
         @(negedge CLOCK_50);
         n++;
      end
      repeat (10) @(negedge CLOCK_50);
      checkOutput("queueDrained", expQ.size(), 0);
      expQ.delete();
   endtask

   initial begin
      reset   = 1'b1;
      PS2_CLK = 1'b1;
      PS2_DAT = 1'b1;
      repeat (3) @(negedge CLOCK_50);
      checkOutput("resetKey", int'(KEY_PRESSED), 31);
      checkOutput("resetStrobe", int'(key_strobe), 0);
      checkOutput("resetError", int'(frame_error), 0);
      reset = 1'b0;
      repeat (5) @(negedge CLOCK_50);
      monitorOn = 1'b1;

      // Player 1 arrow up, then its break.
      expectEvent(K_STROBE, 0, 4);
      sendByte(8'hE0); sendByte(8'h75);
      waitDrain(200);
      expectEvent(K_CHANGE, 31, 4);
      sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h75);
      waitDrain(200);

      // Typematic repeat is silent; a break of another key is ignored.
      expectEvent(K_STROBE, 4, 4);
      sendByte(8'h1D);
      sendByte(8'h1D);
      sendByte(8'hF0); sendByte(8'h1B);
      waitDrain(200);
      checkOutput("heldAfterOtherBreak", int'(KEY_PRESSED), 4);

      // Plain and extended 74 must not alias.
      expectEvent(K_STROBE, 15, 4);
      sendByte(8'h74);
      expectEvent(K_STROBE, 3, 4);
      sendByte(8'hE0); sendByte(8'h74);
      expectEvent(K_CHANGE, 31, 4);
      sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h74);
      waitDrain(200);

      // Space with even parity.
`ifdef PS2_PARITY_CHECK_EN
      expectEvent(K_ERR, 0, 3);
`else
      expectEvent(K_STROBE, 16, 4);
`endif
      applyStimulus(8'h29, 1'b1, 1'b0, 11);
      waitDrain(200);

      // A bad stop bit discards the frame and clears a pending E0, so 75 is the numpad key.
      expectEvent(K_ERR, 0, 3);
      sendByte(8'hE0);
      applyStimulus(8'h75, 1'b0, 1'b1, 11);
      expectEvent(K_STROBE, 12, 4);
      sendByte(8'h75);
      expectEvent(K_CHANGE, 31, 4);
      sendByte(8'hF0); sendByte(8'h75);
      waitDrain(200);

      // Partial frame followed by silence, then a good frame.
      expectEvent(K_ERR, 0, -1);
      applyStimulus(8'h1C, 1'b0, 1'b0, 5);
      waitDrain(60000);
      expectEvent(K_STROBE, 6, 4);
      sendByte(8'h1C);
      waitDrain(200);

      // Reset during a frame: the code clears at once, and the trailing stop bit is harmless.
      expectEvent(K_STROBE, 8, 4);
      sendByte(8'h43);
      waitDrain(200);
      applyStimulus(8'h1D, 1'b0, 1'b0, 10);
      expectEvent(K_CHANGE, 31, -1);
      #3 reset = 1'b1;
      #1 checkOutput("asyncResetKey", int'(KEY_PRESSED), 31);
      repeat (3) @(negedge CLOCK_50);
      reset = 1'b0;
      pulseBit(1'b1);
      waitDrain(200);
      expectEvent(K_STROBE, 9, 4);
      sendByte(8'h42);
      waitDrain(200);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
